// File: rtl/jtframe_ba_rr_arbiter_if.sv
// Bundles the slot-side read requests and the single SDRAM bank read port.
// ba_rd is held with a stable ba_addr until ba_ack; ba_rdy is honoured only with or after ba_ack.
interface jtframe_ba_rr_arbiter_if #(
    parameter int SLOTS = 4,
    parameter int AW    = 22
);
    logic                flush;
    logic [SLOTS*AW-1:0] slot_addr;
    logic [SLOTS-1:0]    slot_cs;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*16-1:0] slot_dout;
    logic [AW-1:0]       ba_addr;
    logic                ba_rd;
    logic                ba_ack;
    logic                ba_rdy;
    logic [15:0]         sdram_dout;
    logic                timeout;

    modport master (
        input  flush, slot_addr, slot_cs, ba_ack, ba_rdy, sdram_dout,
        output slot_ok, slot_dout, ba_addr, ba_rd, timeout
    );

    modport slave (
        output flush, slot_addr, slot_cs, ba_ack, ba_rdy, sdram_dout,
        input  slot_ok, slot_dout, ba_addr, ba_rd, timeout
    );
endinterface

// File: rtl/jtframe_ba_rr_arbiter.sv
// Round-robin sharing of one SDRAM bank read port among SLOTS requesters,
// each with a one-word address-tagged result register.
module jtframe_ba_rr_arbiter #(
    parameter int SLOTS = 4,
    parameter int AW    = 22,
    parameter int TOUT  = 255
)(
    input  logic                           clk,
    input  logic                           rst,
    jtframe_ba_rr_arbiter_if.master        bus,
    output logic [1:0]                     dbg_state
);
    localparam int         PW       = $clog2(SLOTS);
    localparam logic [7:0] CNT_LAST = 8'(TOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_RDY = 2'd2
    } state_t;

    state_t        st, st_nx;
    logic [PW-1:0] gnt, gnt_nx, rr, rr_nx, pick;
    logic [AW-1:0] addr_q, addr_nx;
    logic          rd_q, rd_nx;
    logic [7:0]    cnt, cnt_nx;
    logic          drop, drop_nx;
    logic          store, tout, any_pend;

    logic [AW-1:0]    tag  [SLOTS];
    logic [15:0]      data [SLOTS];
    logic [SLOTS-1:0] valid, hit, pend;

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        assign hit[g] = bus.slot_cs[g] & valid[g] & (tag[g] == bus.slot_addr[g*AW +: AW]);
        assign bus.slot_dout[g*16 +: 16] = data[g];
    end

    assign pend        = bus.slot_cs & ~hit;
    assign bus.slot_ok = hit;
    assign bus.ba_addr = addr_q;
    assign bus.ba_rd   = rd_q;
    assign bus.timeout = tout;
    assign dbg_state   = st;

    // Later iterations overwrite earlier ones, so the slot nearest rr+1 wins.
    always_comb begin : arb_pick
        logic [PW-1:0] idx;
        idx      = '0;
        pick     = '0;
        any_pend = 1'b0;
        for (int k = SLOTS; k >= 1; k--) begin
            idx = PW'((int'(rr) + k) % SLOTS);
            if (pend[idx]) begin
                pick     = idx;
                any_pend = 1'b1;
            end
        end
    end

    always_comb begin
        st_nx   = st;
        gnt_nx  = gnt;
        rr_nx   = rr;
        rd_nx   = rd_q;
        addr_nx = addr_q;
        cnt_nx  = cnt;
        drop_nx = drop;
        store   = 1'b0;
        tout    = 1'b0;
        case (st)
            IDLE: begin
                drop_nx = 1'b0;
                if (any_pend) begin
                    gnt_nx  = pick;
                    addr_nx = bus.slot_addr[int'(pick)*AW +: AW];
                    rd_nx   = 1'b1;
                    st_nx   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.ba_ack) begin
                    rd_nx  = 1'b0;
                    cnt_nx = '0;
                    if (bus.ba_rdy) begin
                        store = 1'b1;
                        rr_nx = gnt;
                        st_nx = IDLE;
                    end else begin
                        st_nx = WAIT_RDY;
                    end
                end
            end
            WAIT_RDY: begin
                if (bus.ba_rdy) begin
                    store = 1'b1;
                    rr_nx = gnt;
                    st_nx = IDLE;
                end else if (cnt == CNT_LAST) begin
                    tout  = 1'b1;
                    rr_nx = gnt;
                    st_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            default: st_nx = IDLE;
        endcase
        // Data already requested before a flush must not come back as valid.
        if (st != IDLE && bus.flush) drop_nx = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= IDLE;
            gnt    <= '0;
            rr     <= PW'(SLOTS - 1);
            rd_q   <= 1'b0;
            addr_q <= '0;
            cnt    <= '0;
            drop   <= 1'b0;
            valid  <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                tag[i]  <= '0;
                data[i] <= '0;
            end
        end else begin
            st     <= st_nx;
            gnt    <= gnt_nx;
            rr     <= rr_nx;
            rd_q   <= rd_nx;
            addr_q <= addr_nx;
            cnt    <= cnt_nx;
            drop   <= drop_nx;
            if (bus.flush) valid <= '0;
            if (store) begin
                data[gnt]  <= bus.sdram_dout;
                tag[gnt]   <= addr_q;
                valid[gnt] <= ~(drop | bus.flush);
            end
        end
    end
endmodule

// File: tb/tb_jtframe_ba_rr_arbiter.sv
// Bench for jtframe_ba_rr_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the slot caches.
module tb_jtframe_ba_rr_arbiter;
    localparam int SLOTS = 4;
    localparam int AW    = 22;
    localparam int TOUT  = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    jtframe_ba_rr_arbiter_if #(.SLOTS(SLOTS), .AW(AW)) bus ();

    jtframe_ba_rr_arbiter #(.SLOTS(SLOTS), .AW(AW), .TOUT(TOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: per-slot cache plus one outstanding bank request
    logic [AW-1:0]    m_tag  [SLOTS];
    logic [15:0]      m_data [SLOTS];
    logic [SLOTS-1:0] m_valid;
    int               m_last;
    logic             m_active, m_acked, m_drop;
    int               m_slot, m_wait;
    logic [AW-1:0]    m_addr;
    logic [AW-1:0]    exp_q[$];
    logic             prev_rd;

    // Bank controller behaviour
    int          ack_dly = 1, rdy_dly = 2, ack_cnt = 0, rdy_cnt = 0;
    bit          rdy_never = 0, noise = 0, rand_dly = 0, rand_dout = 1;
    logic [15:0] dout_fixed = 16'h0;

    function automatic logic [AW-1:0] addr_of(input int i);
        return bus.slot_addr[i*AW +: AW];
    endfunction

    function automatic logic exp_ok(input int i);
        return bus.slot_cs[i] && m_valid[i] && (m_tag[i] == addr_of(i));
    endfunction

    task automatic set_slot(input int i, input logic cs, input logic [AW-1:0] a);
        bus.slot_cs[i] = cs;
        bus.slot_addr[i*AW +: AW] = a;
    endtask

    task automatic check_all();
        for (int i = 0; i < SLOTS; i++) begin
            check($sformatf("ok%0d", i), 32'(bus.slot_ok[i]), 32'(exp_ok(i)));
            check($sformatf("dout%0d", i), 32'(bus.slot_dout[i*16 +: 16]), 32'(m_data[i]));
        end
        check("ba_rd", 32'(bus.ba_rd), 32'(m_active && !m_acked));
        if (m_active) check("ba_addr", 32'(bus.ba_addr), 32'(m_addr));
        check("timeout", 32'(bus.timeout), 32'(m_active && m_acked && !bus.ba_rdy && m_wait == TOUT));
        if (bus.ba_rd && !prev_rd) begin
            check("grant_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("grant_addr", 32'(bus.ba_addr), 32'(exp_q.pop_front()));
        end
        prev_rd = bus.ba_rd;
    endtask

    // Applies what the coming clock edge does, from the spec's rules.
    task automatic model_step();
        int   p;
        logic done, was_active;
        if (rst) begin
            m_valid  = '0;
            for (int i = 0; i < SLOTS; i++) begin
                m_tag[i]  = '0;
                m_data[i] = '0;
            end
            m_last   = SLOTS - 1;
            m_active = 0;
            m_acked  = 0;
            m_drop   = 0;
            m_wait   = 0;
            exp_q.delete();
            return;
        end
        p = -1;
        for (int k = 1; k <= SLOTS; k++) begin
            int j;
            j = (m_last + k) % SLOTS;
            if (p < 0 && bus.slot_cs[j] && !exp_ok(j)) p = j;
        end
        was_active = m_active;
        done = 0;
        if (m_active && !m_acked) begin
            if (bus.ba_ack) begin
                if (bus.ba_rdy) done = 1;
                else begin
                    m_acked = 1;
                    m_wait  = 1;
                end
            end
        end else if (m_active) begin
            if (bus.ba_rdy) done = 1;
            else if (m_wait == TOUT) begin
                m_active = 0;
                m_last   = m_slot;
            end else m_wait++;
        end
        if (bus.flush) begin
            m_valid = '0;
            if (was_active) m_drop = 1;
        end
        if (done) begin
            m_data[m_slot]  = bus.sdram_dout;
            m_tag[m_slot]   = m_addr;
            m_valid[m_slot] = !m_drop;
            m_active        = 0;
            m_last          = m_slot;
        end else if (!was_active) begin
            m_drop = 0;
            if (p >= 0) begin
                m_active = 1;
                m_acked  = 0;
                m_slot   = p;
                m_addr   = addr_of(p);
                exp_q.push_back(m_addr);
                if (rand_dly) begin
                    ack_dly = $urandom_range(0, 3);
                    rdy_dly = $urandom_range(0, 5);
                end
                ack_cnt = ack_dly;
            end
        end
    endtask

    task automatic bank_drive();
        bus.ba_ack = 1'b0;
        bus.ba_rdy = 1'b0;
        bus.sdram_dout = rand_dout ? 16'($urandom) : dout_fixed;
        if (m_active && !m_acked) begin
            if (ack_cnt == 0) begin
                bus.ba_ack = 1'b1;
                rdy_cnt = rdy_dly;
                if (rdy_dly == 0 && !rdy_never) bus.ba_rdy = 1'b1;
            end else begin
                ack_cnt--;
                if (noise && $urandom_range(0, 7) == 0) bus.ba_rdy = 1'b1;
            end
        end else if (m_active) begin
            if (rdy_cnt > 0) rdy_cnt--;
            if (rdy_cnt == 0 && !rdy_never) bus.ba_rdy = 1'b1;
        end else if (noise && $urandom_range(0, 7) == 0) begin
            bus.ba_rdy = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!rst) check_all();
        else prev_rd = 1'b0;
        model_step();
        @(posedge clk);
        #1;
        bank_drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.slot_cs = '0;
        bus.flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int limit, output logic found);
        logic prev;
        found = 1'b0;
        for (int n = 0; n < limit && !found; n++) begin
            prev = bus.ba_rd;
            tick();
            if (!prev && bus.ba_rd) found = 1'b1;
        end
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < SLOTS; i++) begin
            if ($urandom_range(0, 5) == 0) bus.slot_cs[i] = ~bus.slot_cs[i];
            if ($urandom_range(0, 4) == 0) bus.slot_addr[i*AW +: AW] = AW'($urandom_range(0, 5));
        end
        bus.flush = ($urandom_range(0, 49) == 0);
    endtask

    initial begin
        logic          f;
        int            k, grants;
        logic          seen;
        logic [AW-1:0] a0;

        bus.flush      = 1'b0;
        bus.slot_cs    = '0;
        bus.slot_addr  = '0;
        bus.ba_ack     = 1'b0;
        bus.ba_rdy     = 1'b0;
        bus.sdram_dout = '0;
        prev_rd        = 1'b0;

        // Reset state
        do_reset();
        check("rst_ba_rd", 32'(bus.ba_rd), 32'd0);
        check("rst_ba_addr", 32'(bus.ba_addr), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        check("rst_dout", bus.slot_dout[31:0], 32'd0);

        // Single miss then hit
        rand_dout = 0; dout_fixed = 16'hBEEF; ack_dly = 2; rdy_dly = 4;
        set_slot(1, 1'b1, 22'h00100);
        k = 0;
        for (int n = 1; n <= 30 && k == 0; n++) begin
            tick();
            if (bus.slot_ok[1]) k = n;
        end
        check("t1_latency", 32'(k), 32'd8);
        check("t1_dout", 32'(bus.slot_dout[31:16]), 32'hBEEF);
        bus.slot_cs[1] = 1'b0;
        tick();
        bus.slot_cs[1] = 1'b1;
        #1;
        check("t1_hit", 32'(bus.slot_ok[1]), 32'd1);
        for (int n = 0; n < 4; n++) begin
            tick();
            check("t1_no_rd", 32'(bus.ba_rd), 32'd0);
        end

        // Round robin from reset
        do_reset();
        rand_dout = 1; ack_dly = 1; rdy_dly = 2;
        for (int i = 0; i < SLOTS; i++) set_slot(i, 1'b1, AW'(32'h1000 + i));
        for (int i = 0; i < SLOTS; i++) begin
            wait_grant(40, f);
            check("t2_grant", 32'(f), 32'd1);
            check($sformatf("t2_order%0d", i), 32'(bus.ba_addr), 32'h1000 + i);
        end
        for (int n = 0; n < 10; n++) tick();
        check("t2_all_ok", 32'(bus.slot_ok), 32'hF);

        // Starvation guard
        do_reset();
        a0 = 22'h100;
        set_slot(0, 1'b1, a0);
        wait_grant(20, f);
        check("t3_first", 32'(f), 32'd1);
        set_slot(2, 1'b1, 22'h2222);
        grants = 0; seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            f = bus.ba_rd;
            tick();
            if (bus.slot_ok[0]) begin
                a0 = a0 + 1'b1;
                set_slot(0, 1'b1, a0);
            end
            if (!f && bus.ba_rd) begin
                grants++;
                if (bus.ba_addr == 22'h2222) seen = 1'b1;
            end
        end
        check("t3_slot2", 32'(seen), 32'd1);
        check("t3_within2", 32'(grants <= 2), 32'd1);

        // Address change mid-flight
        do_reset();
        ack_dly = 0; rdy_dly = 6;
        set_slot(0, 1'b1, 22'h10);
        wait_grant(10, f);
        tick();
        tick();
        set_slot(0, 1'b1, 22'h20);
        wait_grant(30, f);
        check("t4_regrant", 32'(f), 32'd1);
        check("t4_addr", 32'(bus.ba_addr), 32'h20);
        for (int n = 0; n < 12; n++) tick();
        check("t4_ok", 32'(bus.slot_ok[0]), 32'd1);

        // Flush while waiting for data
        do_reset();
        rand_dout = 0; dout_fixed = 16'h1234; ack_dly = 1; rdy_dly = 5;
        set_slot(3, 1'b1, 22'h333);
        wait_grant(10, f);
        tick();
        tick();
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        seen = 1'b0; f = 1'b0;
        for (int n = 0; n < 30 && !f; n++) begin
            k = int'(bus.ba_rd);
            tick();
            if (bus.slot_ok[3]) seen = 1'b1;
            if (k == 0 && bus.ba_rd) f = 1'b1;
        end
        check("t5_ok_low", 32'(seen), 32'd0);
        check("t5_rereq", 32'(f), 32'd1);
        check("t5_dout", 32'(bus.slot_dout[63:48]), 32'h1234);
        check("t5_addr", 32'(bus.ba_addr), 32'h333);
        rand_dout = 1;

        // Watchdog
        do_reset();
        rdy_never = 1; ack_dly = 0; rdy_dly = 2;
        set_slot(1, 1'b1, 22'h111);
        wait_grant(10, f);
        set_slot(2, 1'b1, 22'h222);
        k = 0;
        for (int n = 1; n <= 400 && k == 0; n++) begin
            tick();
            if (bus.timeout) k = n;
        end
        check("t6_cycles", 32'(k), 32'd255);
        rdy_never = 0;
        tick();
        check("t6_pulse", 32'(bus.timeout), 32'd0);
        wait_grant(20, f);
        check("t6_other_first", 32'(bus.ba_addr), 32'h222);
        wait_grant(30, f);
        check("t6_retry", 32'(bus.ba_addr), 32'h111);

        // Random traffic with noise, flushes and occasional resets
        do_reset();
        noise = 1; rand_dly = 1; rand_dout = 1;
        for (int n = 0; n < 2500; n++) begin
            rand_inputs();
            if ($urandom_range(0, 599) == 0) do_reset();
            else tick();
        end

        // Drain
        noise = 0;
        bus.slot_cs = '0;
        bus.flush = 1'b0;
        for (int n = 0; n < 50 && m_active; n++) tick();
        tick();
        tick();
        check("q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
